// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master: FSM states, frame width and SCLK divider encoding.
// Imported by the interface and the master; holds no logic.
package spi_pkg;

    localparam int FRAME_W    = 16;
    localparam int SCLK_CNT_W = 5;
    localparam int BIT_CNT_W  = $clog2(FRAME_W) + 1;

    // SCLK is the MSB of the divider, so these counts mark the phases of one SCLK period.
    localparam logic [SCLK_CNT_W-1:0] SCLK_IDLE_CNT = 5'b10000;
    localparam logic [SCLK_CNT_W-1:0] SCLK_SMPL_CNT = 5'b11110;
    localparam logic [SCLK_CNT_W-1:0] SCLK_SHFT_CNT = 5'b11111;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT_CNT = BIT_CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Host strobe/command/result plus the four SPI pins of one SPI master.
// master modport is the SPI master itself; slave modport is the host/peripheral side.
interface spi_master_if;
    import spi_pkg::*;

    logic               wrt;
    logic [FRAME_W-1:0] cmd;
    logic               done;
    logic [FRAME_W-1:0] rd_data;
    logic               SS_n;
    logic               SCLK;
    logic               MOSI;
    logic               MISO;

    modport master (
        input  wrt, cmd, MISO,
        output done, rd_data, SS_n, SCLK, MOSI
    );

    modport slave (
        output wrt, cmd, MISO,
        input  done, rd_data, SS_n, SCLK, MOSI
    );

endinterface

// File: rtl/spi_master.sv
// 16-bit SPI master, SCLK = clk/32 idling high; optional 2-flop MISO synchroniser under SPI_MASTER_MISO_SYNC_EN.
// Latency: done rises 529 clk after the accepted wrt cycle; SS_n low from the cycle after wrt.
// Backpressure: none; wrt is only accepted in IDLE and ignored while a frame is in flight.
module spi_master
    import spi_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);

    spi_state_e              state_q, state_d;
    logic [SCLK_CNT_W-1:0]   sclk_cnt_q, sclk_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]      shft_q, shft_d;
    logic                    ss_n_q, ss_n_d;
    logic                    done_q, done_d;
    logic                    miso_smpl_q, miso_smpl_d;
    logic                    miso_in;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q, miso_sync_d;

    assign miso_sync_d = {miso_sync_q[0], bus.MISO};
    assign miso_in     = miso_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sync_q <= 2'b00;
        end else begin
            miso_sync_q <= miso_sync_d;
        end
    end
`else
    assign miso_in = bus.MISO;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.wrt) state_d = FRONT;
            FRONT: if (sclk_cnt_q == SCLK_SHFT_CNT) state_d = SHIFT;
            // Leave SHIFT once all bits are out and SCLK has risen again.
            SHIFT: if (bit_cnt_q == LAST_BIT_CNT && sclk_cnt_q == SCLK_IDLE_CNT) state_d = BACK;
            BACK:  if (sclk_cnt_q == SCLK_SHFT_CNT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sclk_cnt_d  = sclk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shft_d      = shft_q;
        ss_n_d      = ss_n_q;
        done_d      = done_q;
        miso_smpl_d = miso_smpl_q;
        case (state_q)
            IDLE: begin
                sclk_cnt_d = SCLK_IDLE_CNT;
                if (bus.wrt) begin
                    shft_d    = bus.cmd;
                    bit_cnt_d = '0;
                    ss_n_d    = 1'b0;
                    done_d    = 1'b0;
                end
            end
            FRONT, SHIFT: begin
                sclk_cnt_d = sclk_cnt_q + SCLK_CNT_W'(1);
                if (sclk_cnt_q == SCLK_SMPL_CNT) begin
                    miso_smpl_d = miso_in;
                end
                // Shift on the SCLK falling edge, using the bit sampled one clk earlier.
                if (sclk_cnt_q == SCLK_SHFT_CNT) begin
                    shft_d    = {shft_q[FRAME_W-2:0], miso_smpl_q};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            BACK: begin
                if (sclk_cnt_q == SCLK_SHFT_CNT) begin
                    sclk_cnt_d = SCLK_IDLE_CNT;
                    ss_n_d     = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    sclk_cnt_d = sclk_cnt_q + SCLK_CNT_W'(1);
                end
            end
            default: begin
                sclk_cnt_d = SCLK_IDLE_CNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_cnt_q  <= SCLK_IDLE_CNT;
            bit_cnt_q   <= '0;
            shft_q      <= '0;
            ss_n_q      <= 1'b1;
            done_q      <= 1'b0;
            miso_smpl_q <= 1'b0;
        end else begin
            sclk_cnt_q  <= sclk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shft_q      <= shft_d;
            ss_n_q      <= ss_n_d;
            done_q      <= done_d;
            miso_smpl_q <= miso_smpl_d;
        end
    end

    assign bus.SCLK    = sclk_cnt_q[SCLK_CNT_W-1];
    assign bus.SS_n    = ss_n_q;
    assign bus.done    = done_q;
    assign bus.rd_data = shft_q;
    assign bus.MOSI    = ~ss_n_q & shft_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: random and directed frames against a SPI slave model and a frame-level scoreboard.
module tb_spi_master;

    localparam int N_BITS      = 16;
    localparam int FIRST_FALL  = 17;
    localparam int SCLK_PERIOD = 32;
    localparam int DONE_LAT    = FIRST_FALL + SCLK_PERIOD * (N_BITS - 1) + SCLK_PERIOD;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] resp;
        int          t0;
    } frame_t;

    logic clk;
    logic rst_n;
    spi_master_if bus();

    spi_master u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frame_t      sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          busy_until = 0;
    int          last_accept = -100;
    logic [15:0] slave_tx = 16'h0;

    // slave / monitor state
    logic [15:0] slave_rx = 16'h0;
    int          falls = 0;
    int          first_fall = 0;
    logic        hdr_bad = 1'b0;
    logic        mosi_bad = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        prev_mosi = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // One-cycle wrt; the model accepts it only when no frame is in flight.
    task automatic issue(input logic [15:0] c, input logic [15:0] r);
        frame_t f;
        bus.cmd = c;
        bus.wrt = 1'b1;
        if (cyc >= busy_until) begin
            slave_tx = r;
            f.cmd  = c;
            f.resp = r;
            f.t0   = cyc;
            sb_q.push_back(f);
            busy_until  = cyc + DONE_LAT;
            last_accept = cyc;
        end
        @(negedge clk);
        bus.wrt = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ss_n"},    32'(bus.SS_n),    32'd1);
        chk({tag, "_sclk"},    32'(bus.SCLK),    32'd1);
        chk({tag, "_done"},    32'(bus.done),    32'd0);
        chk({tag, "_mosi"},    32'(bus.MOSI),    32'd0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
    endtask

    // Slave model plus scoreboard monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        frame_t f;
        int     d;
        if (!rst_n) begin
            falls    = 0;
            slave_rx = 16'h0;
            hdr_bad  = 1'b0;
            mosi_bad = 1'b0;
            bus.MISO = 1'b0;
        end else begin
            if (bus.done && !prev_done) begin
                chk("done_has_frame", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    f = sb_q.pop_front();
                    chk("done_latency", 32'(cyc - f.t0),  32'(DONE_LAT));
                    chk("rd_data",      32'(bus.rd_data), 32'(f.resp));
                    chk("slave_rx",     32'(slave_rx),    32'(f.cmd));
                    chk("sclk_falls",   32'(falls),       32'(N_BITS));
                    chk("first_fall",   32'(first_fall),  32'(FIRST_FALL));
                    chk("front_porch",  32'(hdr_bad),     32'd0);
                    chk("mosi_idle",    32'(mosi_bad),    32'd0);
                    chk("ss_n_at_done", 32'(bus.SS_n),    32'd1);
                end
                hdr_bad  = 1'b0;
                mosi_bad = 1'b0;
            end
            if (!bus.done && prev_done) begin
                chk("done_hold", 32'(cyc - last_accept), 32'd1);
            end
            if (prev_ss && !bus.SS_n) begin
                falls    = 0;
                slave_rx = 16'h0;
                bus.MISO = slave_tx[15];
            end else if (!bus.SS_n && prev_sclk && !bus.SCLK) begin
                if (falls == 0 && sb_q.size() > 0) first_fall = cyc - sb_q[0].t0;
                falls++;
                slave_rx = {slave_rx[14:0], prev_mosi};
                bus.MISO = (falls < N_BITS) ? slave_tx[15 - falls] : 1'b0;
            end
            if (sb_q.size() > 0) begin
                d = cyc - sb_q[0].t0;
                if (d >= 1 && d <= 16 && (bus.SCLK !== 1'b1 || bus.SS_n !== 1'b0)) hdr_bad = 1'b1;
            end
            if (bus.SS_n && bus.MOSI !== 1'b0) mosi_bad = 1'b1;
        end
        prev_done = bus.done;
        prev_ss   = bus.SS_n;
        prev_sclk = bus.SCLK;
        prev_mosi = bus.MOSI;
    end

    initial begin
        int t0;
        int off;
        rst_n   = 1'b1;
        bus.wrt = 1'b0;
        bus.cmd = 16'h0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer frame, then done must hold while idle.
        issue(16'hA5C3, 16'h3C5A);
        t0 = last_accept;
        wait_until(t0 + DONE_LAT + 40);
        chk("done_held_idle", 32'(bus.done),    32'd1);
        chk("rd_data_held",   32'(bus.rd_data), 32'h3C5A);

        // wrt pulses mid-frame are ignored.
        issue(16'h0001, 16'($urandom));
        t0 = last_accept;
        wait_until(t0 + 100);
        issue(16'hFFFF, 16'hFFFF);
        wait_until(t0 + 300);
        issue(16'hFFFF, 16'hFFFF);
        wait_until(t0 + DONE_LAT + 2);

        // Back-to-back: wrt in the done-setting cycle is ignored, the next one is taken.
        issue(16'h0000, 16'($urandom));
        t0 = last_accept;
        wait_until(t0 + DONE_LAT - 1);
        issue(16'($urandom), 16'($urandom));
        issue(16'hFFFF, 16'($urandom));
        t0 = last_accept;
        wait_until(t0 + DONE_LAT + 3);

        for (int i = 0; i < 6; i++) begin
            issue(16'($urandom), 16'($urandom));
            t0  = last_accept;
            off = $urandom_range(1, DONE_LAT - 1);
            wait_until(t0 + off);
            issue(16'($urandom), 16'($urandom));
            wait_until(t0 + DONE_LAT + $urandom_range(0, 4));
        end

        // Reset mid-frame aborts without done; a fresh frame then completes.
        issue(16'($urandom), 16'($urandom));
        t0 = last_accept;
        wait_until(t0 + 250);
        #2 rst_n = 1'b0;
        sb_q.delete();
        busy_until = 0;
        #1 chk_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h1234, 16'($urandom));
        t0 = last_accept;
        wait_until(t0 + DONE_LAT + 5);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port wrt, input, 1, start-frame strobe, one clk wide.
REQ-004 SHALL have port cmd, input, 16, command word to transmit MSB-first.
REQ-005 SHALL have port done, output, 1, frame-complete flag.
REQ-006 SHALL have port rd_data, output, 16, word received on MISO.
REQ-007 SHALL have port SS_n, output, 1, slave select, active-low.
REQ-008 SHALL have port SCLK, output, 1, serial clock, idles high.
REQ-009 SHALL have port MOSI, output, 1, serial data to slave.
REQ-010 SHALL have port MISO, input, 1, serial data from slave.

Function
REQ-011 SHALL implement a 5-bit counter sclk_cnt, with SCLK = sclk_cnt[4], giving SCLK period = 32 clk.
REQ-012 SHALL implement a state machine with states IDLE, FRONT, SHIFT, BACK.
REQ-013 In IDLE, sclk_cnt SHALL be held at 5'b10000, SS_n SHALL be 1, and SCLK SHALL be 1.
REQ-014 On wrt=1 in IDLE at cycle T0:
  - shft_reg <= cmd
  - SS_n <= 0
  - done <= 0
  - state <= FRONT
  - sclk_cnt SHALL count from T1.
REQ-015 wrt while not IDLE SHALL be ignored: no reload, done unchanged.
REQ-016 MOSI SHALL equal shft_reg[15] whenever SS_n=0, and SHALL be 0 otherwise.
REQ-017 miso_smpl SHALL capture MISO in every cycle with sclk_cnt==5'b11110 in FRONT or SHIFT.
REQ-018 shft_reg <= {shft_reg[14:0], miso_smpl} SHALL occur in every cycle with sclk_cnt==5'b11111 in FRONT or SHIFT; this is the SCLK falling edge.
REQ-019 A 5-bit bit counter SHALL increment once per shift; FRONT SHALL go to SHIFT on the first shift.
REQ-020 After the 16th shift, SHIFT SHALL go to BACK when sclk_cnt reaches 5'b10000 (SCLK rising).
REQ-021 In BACK, SCLK SHALL stay high; in the cycle with sclk_cnt==5'b11111:
  - SS_n <= 1
  - done <= 1
  - state <= IDLE
  - sclk_cnt <= 5'b10000.
REQ-022 Timing from wrt at T0:
  - first falling edge at T17
  - k-th falling edge at T17+32(k-1)
  - last falling edge at T497
  - SS_n=1 and done=1 at T529.
REQ-023 rd_data SHALL equal shft_reg and SHALL be valid whenever done=1.
REQ-024 done SHALL remain 1 until the next accepted wrt.
REQ-025 wrt in the same cycle that done is set (IDLE entry) SHALL be ignored; wrt is accepted from the next cycle.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately force:
  - state=IDLE, SS_n=1, SCLK=1, done=0
  - sclk_cnt=5'b10000, bit counter=0
  - shft_reg=0, rd_data=0, MOSI=0.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; SS_n rising SHALL be visible asynchronously.

Configuration
REQ-028 With SPI_MASTER_MISO_SYNC_EN defined, MISO SHALL pass through two flops before miso_smpl; timing per REQ-022 SHALL be unchanged.
REQ-029 Without SPI_MASTER_MISO_SYNC_EN, miso_smpl SHALL sample MISO directly.

Structure
REQ-030 Package spi_pkg SHALL hold:
  - the state enum (IDLE/FRONT/SHIFT/BACK)
  - FRAME_W=16
  - SCLK_CNT_W=5
  - SCLK_IDLE_CNT=5'b10000.
REQ-031 No sub-module SHALL be used; the counter, the shifter and the FSM SHALL be in one module.

Verification
REQ-032 Reset, then wrt with cmd=16'hA5C3 and MISO fed from a slave model returning 16'h3C5A SHALL give done=1 at T529, rd_data=16'h3C5A, and a slave-captured word of 16'hA5C3.
REQ-033 Counting from wrt SHALL show exactly 16 SCLK falling edges, the first at T17, with SCLK high and SS_n=0 throughout T1..T16.
REQ-034 wrt pulses of 16'hFFFF at T100 and T300 during a frame with cmd=16'h0001 SHALL leave the transmitted word 16'h0001 with a single done.
REQ-035 rst_n=0 at T250 SHALL give SS_n=1, SCLK=1, done=0 immediately; a fresh wrt with 16'h1234 SHALL then complete normally.
REQ-036 Back-to-back frames 16'h0000 then 16'hFFFF, with wrt one cycle after done, SHALL give correct rd_data for each frame and SS_n high for at least 1 clk between frames.
REQ-037 With SPI_MASTER_MISO_SYNC_EN defined, REQ-032 SHALL pass with identical timing.
